// File: rtl/cfg_sequencer_pkg.sv
// Shared types and defaults for the Si5340 configuration sequencer.
// Build option: CFG_RETRY_EN enables re-sending a NACKed I2C transaction.
package cfg_sequencer_pkg;

  localparam int CLK_FREQ     = 125_000_000;
  localparam int WORD_NUMBER  = 326;
  localparam int MEM_WIDTH    = 24;
  localparam int DATA_WIDTH   = 8;
  localparam int PAUSE_WORD   = 3;
  // 300 ms settle time after the preamble
  localparam int PAUSE_CYCLES = CLK_FREQ * 3 / 10;
  localparam int RETRY_MAX    = 3;

  localparam logic [6:0] SLAVE_ADDR = 7'h74;
  localparam logic [7:0] PAGE_REG   = 8'h01;

  typedef enum logic {
    WRITE = 1'b0,
    READ  = 1'b1
  } r_w_e;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    WAIT_ROM,
    CHECK,
    SEND_PAGE,
    SEND_REG,
    WAIT_DONE,
    NEXT,
    PAUSE,
    DONE,
    ERROR
  } state_e;

endpackage

// File: rtl/cfg_sequencer_pause_timer.sv
// Down-counting delay timer: loaded while idle, counts while enabled and
// flags the last enabled cycle so the caller spends exactly CYCLES cycles.
module cfg_pause_timer #(
  parameter int CYCLES = 10
) (
  input  logic clk_i,
  input  logic arstn_i,
  input  logic load_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int W = (CYCLES < 1) ? 1 : $clog2(CYCLES + 1);

  logic [W-1:0] cnt;

  // Reload on request, otherwise count down to zero while enabled
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      cnt <= '0;
    end else if (load_i) begin
      cnt <= W'(CYCLES);
    end else if (en_i && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  // A zero-length setting still yields a single pause cycle
  assign tc_o = en_i && (cnt <= W'(1));

endmodule

// File: rtl/cfg_sequencer.sv
// Walks the Si5340 configuration ROM and feeds page-select and register
// writes to a byte-level I2C write master, with one settle pause after the
// preamble. Build option: CFG_RETRY_EN re-sends a NACKed transaction up to
// RETRY_MAX times before giving up.
module cfg_sequencer
  import cfg_sequencer_pkg::*;
#(
  parameter int         WORD_NUMBER  = cfg_sequencer_pkg::WORD_NUMBER,
  parameter int         MEM_WIDTH    = cfg_sequencer_pkg::MEM_WIDTH,
  parameter int         DATA_WIDTH   = cfg_sequencer_pkg::DATA_WIDTH,
  parameter int         PAUSE_WORD   = cfg_sequencer_pkg::PAUSE_WORD,
  parameter int         PAUSE_CYCLES = cfg_sequencer_pkg::PAUSE_CYCLES,
  parameter logic [6:0] SLAVE_ADDR   = cfg_sequencer_pkg::SLAVE_ADDR
) (
  input  logic                           clk_i,
  input  logic                           arstn_i,
  input  logic                           start_i,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           err_o,
  output logic [$clog2(WORD_NUMBER)-1:0] rom_addr_o,
  input  logic [MEM_WIDTH-1:0]           rom_data_i,
  output logic                           tx_valid_o,
  input  logic                           tx_ready_i,
  output logic [DATA_WIDTH-1:0]          tx_data_o,
  output logic                           tx_start_o,
  output logic                           tx_stop_o,
  input  logic                           txn_done_i,
  input  logic                           txn_nack_i
);

  localparam int AW = $clog2(WORD_NUMBER);
  localparam int CW = $clog2(WORD_NUMBER + 1);
  localparam bit HAS_PAUSE = (PAUSE_WORD > 0) && (PAUSE_WORD < WORD_NUMBER);

  state_e                  state;
  logic [CW-1:0]           word_cnt;
  logic [CW-1:0]           cnt_inc;
  logic [1:0]              byte_idx;
  logic                    is_page;
  logic                    page_valid;
  logic [MEM_WIDTH-1:0]    word_q;
  logic [DATA_WIDTH-1:0]   cur_page;
  logic [DATA_WIDTH-1:0]   cur_byte;
  logic                    pause_tc;
`ifdef CFG_RETRY_EN
  logic [1:0]              retry_cnt;
`endif

  wire [DATA_WIDTH-1:0] w_page = word_q[3*DATA_WIDTH-1:2*DATA_WIDTH];
  wire [DATA_WIDTH-1:0] w_reg  = word_q[2*DATA_WIDTH-1:DATA_WIDTH];
  wire [DATA_WIDTH-1:0] w_data = word_q[DATA_WIDTH-1:0];

  assign cnt_inc = word_cnt + CW'(1);

  // Byte to present for the current position of a 3-byte write
  always_comb begin
    cur_byte = {SLAVE_ADDR, WRITE};
    case (byte_idx)
      2'd0:    cur_byte = {SLAVE_ADDR, WRITE};
      2'd1:    cur_byte = is_page ? PAGE_REG : w_reg;
      default: cur_byte = is_page ? w_page : w_data;
    endcase
  end

  cfg_pause_timer #(
    .CYCLES (PAUSE_CYCLES)
  ) u_pause (
    .clk_i   (clk_i),
    .arstn_i (arstn_i),
    .load_i  (state != PAUSE),
    .en_i    (state == PAUSE),
    .tc_o    (pause_tc)
  );

  // Fetched word and last written page; both are gated by FSM state/flags
  always_ff @(posedge clk_i) begin
    if (state == WAIT_ROM) begin
      word_q <= rom_data_i;
    end
    if ((state == WAIT_DONE) && txn_done_i && !txn_nack_i && is_page) begin
      cur_page <= w_page;
    end
  end

  // Load sequencer FSM with registered handshake and status outputs
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state      <= IDLE;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      rom_addr_o <= '0;
      tx_valid_o <= 1'b0;
      tx_data_o  <= '0;
      tx_start_o <= 1'b0;
      tx_stop_o  <= 1'b0;
      word_cnt   <= '0;
      byte_idx   <= '0;
      is_page    <= 1'b0;
      page_valid <= 1'b0;
`ifdef CFG_RETRY_EN
      retry_cnt  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            state      <= FETCH;
            busy_o     <= 1'b1;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            word_cnt   <= '0;
            page_valid <= 1'b0;
          end
        end

        FETCH: begin
          rom_addr_o <= word_cnt[AW-1:0];
          state      <= WAIT_ROM;
        end

        WAIT_ROM: state <= CHECK;

        CHECK: begin
          byte_idx <= '0;
`ifdef CFG_RETRY_EN
          retry_cnt <= '0;
`endif
          if (!page_valid || (w_page != cur_page)) begin
            is_page <= 1'b1;
            state   <= SEND_PAGE;
          end else begin
            is_page <= 1'b0;
            state   <= SEND_REG;
          end
        end

        SEND_PAGE, SEND_REG: begin
          if (tx_valid_o) begin
            if (tx_ready_i) begin
              tx_valid_o <= 1'b0;
              tx_start_o <= 1'b0;
              tx_stop_o  <= 1'b0;
              if (byte_idx == 2'd2) begin
                state <= WAIT_DONE;
              end else begin
                byte_idx <= byte_idx + 2'd1;
              end
            end
          end else begin
            tx_valid_o <= 1'b1;
            tx_data_o  <= cur_byte;
            tx_start_o <= (byte_idx == 2'd0);
            tx_stop_o  <= (byte_idx == 2'd2);
          end
        end

        WAIT_DONE: begin
          if (txn_done_i) begin
            if (!txn_nack_i) begin
              if (is_page) begin
                page_valid <= 1'b1;
                is_page    <= 1'b0;
                byte_idx   <= '0;
`ifdef CFG_RETRY_EN
                retry_cnt  <= '0;
`endif
                state      <= SEND_REG;
              end else begin
                state <= NEXT;
              end
            end else begin
              // Force a page rewrite before the next register write
              page_valid <= 1'b0;
`ifdef CFG_RETRY_EN
              if (retry_cnt < 2'(RETRY_MAX)) begin
                retry_cnt <= retry_cnt + 2'd1;
                byte_idx  <= '0;
                state     <= is_page ? SEND_PAGE : SEND_REG;
              end else begin
                err_o  <= 1'b1;
                busy_o <= 1'b0;
                state  <= ERROR;
              end
`else
              err_o  <= 1'b1;
              busy_o <= 1'b0;
              state  <= ERROR;
`endif
            end
          end
        end

        NEXT: begin
          word_cnt <= cnt_inc;
          if (cnt_inc == CW'(WORD_NUMBER)) begin
            done_o <= 1'b1;
            busy_o <= 1'b0;
            state  <= DONE;
          end else if (HAS_PAUSE && (cnt_inc == CW'(PAUSE_WORD))) begin
            state <= PAUSE;
          end else begin
            state <= FETCH;
          end
        end

        PAUSE: begin
          if (pause_tc) state <= FETCH;
        end

        DONE:    state <= IDLE;
        ERROR:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_sequencer.sv
// Bench for cfg_sequencer: a small ROM, a behavioural I2C byte master and a
// scoreboard of expected bytes built from a reference load model.
module tb_cfg_sequencer;

  localparam int WN = 4;
  localparam int PW = 2;
  localparam int PC = 10;
  localparam int AW = $clog2(WN);

  logic          clk_i = 1'b0;
  logic          arstn_i = 1'b0;
  logic          start_i = 1'b0;
  logic          busy_o, done_o, err_o;
  logic [AW-1:0] rom_addr_o;
  logic [23:0]   rom_data_i;
  logic          tx_valid_o, tx_ready_i, tx_start_o, tx_stop_o;
  logic [7:0]    tx_data_o;
  logic          txn_done_i, txn_nack_i;

  logic [23:0] rom [WN];
  assign rom_data_i = rom[rom_addr_o];

  always #5 clk_i = ~clk_i;

  cfg_sequencer #(
    .WORD_NUMBER  (WN),
    .MEM_WIDTH    (24),
    .DATA_WIDTH   (8),
    .PAUSE_WORD   (PW),
    .PAUSE_CYCLES (PC),
    .SLAVE_ADDR   (7'h74)
  ) dut (
    .clk_i      (clk_i),
    .arstn_i    (arstn_i),
    .start_i    (start_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .rom_addr_o (rom_addr_o),
    .rom_data_i (rom_data_i),
    .tx_valid_o (tx_valid_o),
    .tx_ready_i (tx_ready_i),
    .tx_data_o  (tx_data_o),
    .tx_start_o (tx_start_o),
    .tx_stop_o  (tx_stop_o),
    .txn_done_i (txn_done_i),
    .txn_nack_i (txn_nack_i)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard entries: {start, stop, data}
  typedef logic [9:0] sb_t;
  sb_t sb[$];

  int  cyc = 0, txn_cnt = 0, bytes_seen = 0, pend = 0, lo_left = 0, done_cyc = 0;
  int  nack_lo = 0, nack_hi = 0;
  bit  stall_en = 0, hold = 0, gap_arm = 0;
  sb_t held;
  int  gaps[$];

  // I2C byte master model, acting on the falling edge
  initial begin
    tx_ready_i = 1'b0;
    txn_done_i = 1'b0;
    txn_nack_i = 1'b0;
    forever begin
      @(negedge clk_i);
      cyc++;
      txn_done_i = 1'b0;
      txn_nack_i = 1'b0;
      if (!arstn_i) begin
        pend = 0;
        hold = 0;
        gap_arm = 0;
        tx_ready_i = 1'b0;
      end else begin
        if (hold) begin
          check("hold_stable", {tx_valid_o, tx_start_o, tx_stop_o, tx_data_o}, {1'b1, held});
        end
        if (gap_arm && tx_valid_o) begin
          gaps.push_back(cyc - done_cyc);
          gap_arm = 0;
        end
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            txn_cnt++;
            txn_done_i = 1'b1;
            txn_nack_i = (txn_cnt >= nack_lo) && (txn_cnt < nack_hi);
            done_cyc = cyc;
            gap_arm = 1;
          end
        end
        if (stall_en) begin
          if (lo_left > 0) begin
            tx_ready_i = 1'b0;
            if (tx_valid_o) lo_left--;
          end else begin
            tx_ready_i = ($urandom_range(0, 2) != 0);
          end
        end else begin
          tx_ready_i = 1'b1;
        end
        hold = tx_valid_o && !tx_ready_i;
        held = {tx_start_o, tx_stop_o, tx_data_o};
        if (tx_valid_o && tx_ready_i) begin
          bytes_seen++;
          if (sb.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL extra_byte: got 0x%0h, expected no byte", {tx_start_o, tx_stop_o, tx_data_o});
          end else begin
            check("tx_byte", {tx_start_o, tx_stop_o, tx_data_o}, sb.pop_front());
          end
          if (tx_stop_o) pend = 3;
        end
      end
    end
  end

  // Reference model of one 3-byte write including retries
  task automatic model_txn(input logic [7:0] b1, input logic [7:0] b2, input int nfirst,
                           input int nacks, inout int t, inout bit pv, output bit ok);
`ifdef CFG_RETRY_EN
    int maxa = 4;
`else
    int maxa = 1;
`endif
    ok = 0;
    for (int a = 0; a < maxa && !ok; a++) begin
      t++;
      sb.push_back({2'b10, 8'hE8});
      sb.push_back({2'b00, b1});
      sb.push_back({2'b01, b2});
      if (t >= nfirst && t < nfirst + nacks) pv = 0;
      else ok = 1;
    end
  endtask

  // Reference model of a whole load: pushes expected bytes
  task automatic model_load(input int nfirst, input int nacks);
    bit pv = 0;
    bit ok;
    logic [7:0] cp = 8'h00;
    logic [7:0] pg;
    int t = 0;
    for (int w = 0; w < WN; w++) begin
      pg = rom[w][23:16];
      if (!pv || pg != cp) begin
        model_txn(8'h01, pg, nfirst, nacks, t, pv, ok);
        if (!ok) break;
        cp = pg;
        pv = 1;
      end
      model_txn(rom[w][15:8], rom[w][7:0], nfirst, nacks, t, pv, ok);
      if (!ok) break;
    end
  endtask

  typedef struct {
    logic [3:0][23:0] w;
    int nfirst;
    int nacks;
    bit stall;
    bit restart;
    bit gapchk;
    int exp_n;
    bit exp_done;
    bit exp_err;
  } vec_t;

  vec_t tbl[7];
  int   bytes_base;

  task automatic kick(input vec_t v);
    for (int k = 0; k < WN; k++) rom[k] = v.w[k];
    sb.delete();
    gaps.delete();
    nack_lo = txn_cnt + v.nfirst;
    nack_hi = (v.nfirst == 0) ? nack_lo : nack_lo + v.nacks;
    stall_en = v.stall;
    lo_left = v.stall ? 5 : 0;
    bytes_base = bytes_seen;
    model_load(v.nfirst, (v.nfirst == 0) ? 0 : v.nacks);
    @(negedge clk_i);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic finish_load(input string tag, input vec_t v);
    int c = 0;
    while (!(done_o || err_o) && c < 3000) begin
      @(negedge clk_i);
      c++;
      start_i = (v.restart && c == 30);
    end
    start_i = 1'b0;
    if (c >= 3000) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s_timeout: got no done/err after %0d cycles, expected completion", tag, c);
    end
    repeat (20) @(negedge clk_i);
    check({tag, "_done"}, done_o, v.exp_done);
    check({tag, "_err"}, err_o, v.exp_err);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_valid_idle"}, tx_valid_o, 0);
    check({tag, "_nbytes"}, bytes_seen - bytes_base, v.exp_n);
    check({tag, "_sb_left"}, sb.size(), 0);
    if (v.gapchk) begin
      if (gaps.size() >= 3) check({tag, "_pause_gap"}, gaps[2] - gaps[1], PC);
      else check({tag, "_gap_count"}, gaps.size(), 3);
    end
  endtask

  task automatic set_row(input int i, input logic [23:0] w0, w1, w2, w3, input int nfirst,
                         input int nacks, input bit stall, input bit restart, input bit gapchk,
                         input int exp_n, input bit exp_done, input bit exp_err);
    tbl[i].w = {w3, w2, w1, w0};
    tbl[i].nfirst = nfirst;
    tbl[i].nacks = nacks;
    tbl[i].stall = stall;
    tbl[i].restart = restart;
    tbl[i].gapchk = gapchk;
    tbl[i].exp_n = exp_n;
    tbl[i].exp_done = exp_done;
    tbl[i].exp_err = exp_err;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: got simulation still running, expected finish");
    $fatal(1);
  end

  initial begin
    int c;
    set_row(0, 24'h000B24, 24'h000B25, 24'h0A0102, 24'h0A0203, 0, 0, 0, 0, 1, 18, 1, 0);
    set_row(1, 24'h050010, 24'h050111, 24'h050212, 24'h050313, 0, 0, 0, 0, 0, 15, 1, 0);
    set_row(3, 24'h000B24, 24'h000B25, 24'h0A0102, 24'h0A0203, 0, 0, 1, 0, 0, 18, 1, 0);
    set_row(4, 24'h010011, 24'h020022, 24'h030033, 24'h040044, 0, 0, 0, 1, 0, 24, 1, 0);
`ifdef CFG_RETRY_EN
    set_row(2, 24'h000B24, 24'h000B25, 24'h0A0102, 24'h0A0203, 2, 1, 0, 0, 0, 24, 1, 0);
    set_row(5, 24'h000B24, 24'h000B25, 24'h0A0102, 24'h0A0203, 1, 2, 0, 0, 0, 24, 1, 0);
    set_row(6, 24'h000B24, 24'h000B25, 24'h0A0102, 24'h0A0203, 3, 4, 0, 0, 0, 18, 0, 1);
`else
    set_row(2, 24'h000B24, 24'h000B25, 24'h0A0102, 24'h0A0203, 2, 1, 0, 0, 0, 6, 0, 1);
    set_row(5, 24'h000B24, 24'h000B25, 24'h0A0102, 24'h0A0203, 1, 2, 0, 0, 0, 3, 0, 1);
    set_row(6, 24'h000B24, 24'h000B25, 24'h0A0102, 24'h0A0203, 3, 4, 0, 0, 0, 9, 0, 1);
`endif
    for (int k = 0; k < WN; k++) rom[k] = tbl[0].w[k];

    // Reset state
    repeat (3) @(negedge clk_i);
    check("rst_busy", busy_o, 0);
    check("rst_status", {done_o, err_o}, 0);
    check("rst_tx", {tx_valid_o, tx_start_o, tx_stop_o, tx_data_o}, 0);
    check("rst_addr", rom_addr_o, 0);
    arstn_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check("idle_busy", busy_o, 0);
    check("idle_valid", tx_valid_o, 0);

    // Table of complete loads
    for (int i = 0; i < 7; i++) begin
      kick(tbl[i]);
      finish_load($sformatf("row%0d", i), tbl[i]);
    end

    // Reset asserted in the middle of the pause
    kick(tbl[0]);
    c = 0;
    while (txn_cnt < 3 + (nack_lo - 0) - 0 && c < 2000) begin
      @(negedge clk_i);
      c++;
      if (txn_cnt - (nack_lo) >= 3) break;
    end
    repeat (4) @(negedge clk_i);
    check("pause_busy", busy_o, 1);
    check("pause_valid", tx_valid_o, 0);
    #2 arstn_i = 1'b0;
    #1;
    check("arst_busy", busy_o, 0);
    check("arst_status", {done_o, err_o}, 0);
    check("arst_tx", {tx_valid_o, tx_start_o, tx_stop_o, tx_data_o}, 0);
    check("arst_addr", rom_addr_o, 0);
    repeat (3) @(negedge clk_i);
    arstn_i = 1'b1;
    repeat (2) @(negedge clk_i);
    kick(tbl[0]);
    finish_load("restart", tbl[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
